// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared types and constants for the binary-to-BCD converter
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FINISH
  } state_t;

  localparam int BCD_W = 4;

  // Smallest digit count whose decimal range covers every IN_W-bit value.
  function automatic int min_digits(input int in_w);
    logic [127:0] lim;
    logic [127:0] pow;
    int           d;
    lim = (128'd1 << in_w) - 128'd1;
    pow = 128'd10;
    d   = 1;
    while (pow <= lim) begin
      pow = pow * 128'd10;
      d   = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - combinational add-3 correction for one BCD digit
module bcd_digit_adjust
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted
);

  assign adjusted = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [IN_W-1:0]         bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int CNT_W    = $clog2(IN_W + 1);

  if (DIGITS < min_digits(IN_W)) begin : g_digits_check
    $error("bin_to_bcd_seq: DIGITS too small to hold every IN_W-bit value");
  end

  state_t              state;
  state_t              state_nx;
  logic [BCD_BITS-1:0] scratch;
  logic [BCD_BITS-1:0] adjusted;
  logic [IN_W-1:0]     shreg;
  logic [CNT_W-1:0]    cnt;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch[i*BCD_W +: BCD_W]),
      .adjusted (adjusted[i*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_SHIFT;
      ST_SHIFT:  if (cnt == CNT_W'(1)) state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // done defaults low every edge so the FINISH pulse lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      shreg   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            cnt     <= CNT_W'(IN_W);
            busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          {scratch, shreg} <= {adjusted, shreg} << 1;
          cnt              <= cnt - CNT_W'(1);
        end
        ST_FINISH: begin
          bcd_out <= scratch;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq at 16-bit and 8-bit widths
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec_t;

  typedef struct {
    logic [19:0] bcd;
    int          t0;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] bin_a;
  logic [7:0]  bin_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [19:0] bcd_a;
  logic [11:0] bcd_b;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t q_a[$];
  exp_t q_b[$];

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a)
  );

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (q_a.size() == 0) begin
        check("spurious_done_a", 32'(done_a), 32'd0);
      end else begin
        exp_t e;
        logic ok;
        e = q_a.pop_front();
        check("bcd_a", 32'(bcd_a), 32'(e.bcd));
        check("latency_a", 32'(cyc - e.t0), 32'd17);
        check("busy_at_done_a", 32'(busy_a), 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) if (bcd_a[i*4 +: 4] > 4'd9) ok = 1'b0;
        check("digit_range_a", 32'(ok), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_b) begin
      if (q_b.size() == 0) begin
        check("spurious_done_b", 32'(done_b), 32'd0);
      end else begin
        exp_t e;
        logic ok;
        e = q_b.pop_front();
        check("bcd_b", 32'(bcd_b), 32'(e.bcd[11:0]));
        check("latency_b", 32'(cyc - e.t0), 32'd9);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) if (bcd_b[i*4 +: 4] > 4'd9) ok = 1'b0;
        check("digit_range_b", 32'(ok), 32'd1);
      end
    end
  end

  // Drives one accepted start; bin_in is scrambled afterwards to prove it is sampled once.
  task automatic apply_a(input logic [15:0] v, input logic [19:0] exp);
    exp_t e;
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = v;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    bin_a   = 16'($urandom);
    e.bcd   = exp;
    e.t0    = cyc;
    q_a.push_back(e);
  endtask

  task automatic apply_b(input logic [7:0] v);
    exp_t e;
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = v;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    bin_b   = 8'($urandom);
    e.bcd   = ref_bcd(int'(v));
    e.t0    = cyc;
    q_b.push_back(e);
  endtask

  task automatic wait_empty_a(input string name);
    int n = 0;
    while (q_a.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0) begin
      check({name, "_timeout"}, 32'(q_a.size()), 32'd0);
      q_a.delete();
    end
  endtask

  task automatic wait_empty_b(input string name);
    int n = 0;
    while (q_b.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q_b.size() != 0) begin
      check({name, "_timeout"}, 32'(q_b.size()), 32'd0);
      q_b.delete();
    end
  endtask

  initial begin
    vec_t vecs[6];
    logic ok;
    int   dones;

    vecs[0] = '{16'hFFFF, 20'h65535};
    vecs[1] = '{16'd1234, 20'h01234};
    vecs[2] = '{16'd9,    20'h00009};
    vecs[3] = '{16'd10,   20'h00010};
    vecs[4] = '{16'd50000, 20'h50000};
    vecs[5] = '{16'd99,   20'h00099};

    cyc = 0; n_checks = 0; n_fail = 0;
    start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    rst_n = 1'b0;
    #12;
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_done", 32'(done_a), 32'd0);
    check("reset_bcd", 32'(bcd_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero input: busy must stay high with no done for the 16 cycles before FINISH.
    apply_a(16'd0, 20'h00000);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!busy_a || done_a) ok = 1'b0;
    end
    check("busy_window", 32'(ok), 32'd1);
    wait_empty_a("zero");

    for (int i = 0; i < 6; i++) begin
      apply_a(vecs[i].bin, vecs[i].bcd);
      wait_empty_a("table");
    end

    // Second start at E5 lands while busy and must be dropped.
    apply_a(16'd500, 20'h00500);
    repeat (5) @(negedge clk);
    start_a = 1'b1;
    bin_a   = 16'd777;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_empty_a("ignored_start");
    repeat (20) @(negedge clk);
    check("held_after_ignore", 32'(bcd_a), 32'h00500);

    // Back-to-back: start raised during the done cycle.
    apply_a(16'd100, 20'h00100);
    begin
      int n = 0;
      while (!done_a && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("b2b_first_done_seen", 32'(done_a), 32'd1);
    end
    start_a = 1'b1;
    bin_a   = 16'd42;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    q_a.push_back('{20'h00042, cyc});
    wait_empty_a("b2b");

    // Reset mid-conversion.
    apply_a(16'd9999, 20'h09999);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_bcd", 32'(bcd_a), 32'd0);
    q_a.delete();
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    rst_n = 1'b1;
    repeat (22) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    apply_a(16'd9999, 20'h09999);
    wait_empty_a("after_abort");

    fork
      for (int i = 0; i < 1000; i++) begin
        logic [15:0] v;
        v = 16'($urandom_range(0, 65535));
        apply_a(v, ref_bcd(int'(v)));
        wait_empty_a("sweep16");
      end
      for (int i = 0; i < 1000; i++) begin
        apply_b(8'($urandom_range(0, 255)));
        wait_empty_b("sweep8");
      end
    join

    apply_b(8'd255);
    wait_empty_b("max8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) that turns the multiplier's binary product into packed BCD digits. Each 4-bit digit it produces feeds one instance of the team's BCD-to-7-segment decoder. A start/busy/done handshake lets the result register hold a stable display value while the next conversion runs.

## Interface
- `IN_W`, default 16: binary input width.
- `DIGITS`, default 5: number of BCD output digits. Elaboration must fail unless 10^DIGITS > 2^IN_W − 1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a conversion. Sampled only in IDLE.
- `bin_in` input IN_W: unsigned binary value, captured on the accepting edge.
- `busy` output 1: high while a conversion is in flight.
- `done` output 1: one-cycle pulse when `bcd_out` updates.
- `bcd_out` output 4*DIGITS: packed BCD result. Digit 0 is in bits [3:0] (units), and higher digits follow upward.

## Operation
- FSM states:
  - IDLE → SHIFT on `start`=1.
  - SHIFT loops for IN_W iterations, then goes to FINISH.
  - FINISH → IDLE unconditionally.
- Accept, at edge E0, from IDLE with `start`=1:
  - Load the shift register with `bin_in`.
  - Clear the BCD scratch register (4*DIGITS bits).
  - Set the iteration counter to IN_W.
- SHIFT iteration, one per edge:
  - Every scratch digit ≥ 5 gets +3 (4-bit add, no carry out).
  - Then shift {scratch, shift register} left by 1, bringing the binary MSB into scratch bit 0.
  - Decrement the counter. The edge that performs the last iteration moves the FSM to FINISH.
- FINISH:
  - `bcd_out` ← scratch.
  - `done` ← 1 for exactly one cycle.
  - `busy` ← 0.
  - FSM → IDLE.
- `bcd_out` holds its value until the next FINISH. Every digit is always in 0–9.
- Unused leading digits are 0. No leading-zero blanking is done here.
- `start` is ignored while `busy`=1. It is not queued.
- `bin_in` is only sampled on the accepting edge, so changes mid-conversion have no effect.

## Timing
- Reset value (asynchronous, while `rst_n`=0) of every output: `busy`=0, `done`=0, `bcd_out`=0. FSM goes to IDLE, and the scratch, shift and counter registers are cleared.
- Latency: with `start` accepted at edge E0, iterations run on E1…E_IN_W and FINISH completes at E_(IN_W+1). `done` and the new `bcd_out` are visible after E_(IN_W+1). With the default IN_W, that is 17 cycles.
- `busy` is high from after E0 through E_(IN_W+1), and falls on the same edge `done` rises.
- Back-to-back: `start`=1 during the cycle `done`=1 is accepted, because the FSM is already in IDLE. Throughput is one conversion per IN_W+2 cycles.
- Reset mid-conversion aborts it immediately:
  - `done` never pulses.
  - `bcd_out` returns to 0.
  - The first `start` after `rst_n` deasserts is accepted normally.
- All outputs are registered, with no combinational path from input to output.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, SHIFT, FINISH);
  - the BCD digit width constant (4);
  - a constant function computing the minimum DIGITS for a given IN_W, used by the elaboration check.
- One sub-module, `bcd_digit_adjust`: combinational 4-bit "if ≥5 then +3" cell. It is instantiated DIGITS times in a generate loop.

## Test plan
- Reset, then `start` with `bin_in`=0: `done` pulses once, exactly 17 cycles after the accepting edge, with `bcd_out`=20'h00000 and `busy` high for the preceding cycles.
- `bin_in`=16'hFFFF (65535): `bcd_out`=20'h65535. `bin_in`=1234: `bcd_out`=20'h01234. `bin_in`=9: `bcd_out`=20'h00009.
- Pulse `start` with 500 at E0, then again with 777 at E5: only one `done`, with `bcd_out`=20'h00500.
- Assert `start` with 42 during the `done` cycle of a conversion of 100:
  - first `done` gives 20'h00100;
  - second `done`, 18 cycles later, gives 20'h00042.
- Pull `rst_n` low at cycle 8 of a conversion of 9999:
  - outputs go to 0 at once, asynchronously;
  - no `done` pulse appears;
  - a fresh `start` with 9999 after release gives 20'h09999.
- Random sweep of 1000 values at IN_W=16 and IN_W=8 (DIGITS=3): every result matches the reference model, every digit is ≤ 9, and latency is IN_W+1.
